// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared mode codes and seven-segment encodings
package seg7_scan_driver_pkg;

    localparam logic [1:0] MODE_ID   = 2'b00;
    localparam logic [1:0] MODE_DATA = 2'b01;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7_encode(input logic [3:0] i_digit);
        logic [6:0] r_code;
        case (i_digit)
            4'd0:    r_code = 7'h3F;
            4'd1:    r_code = 7'h06;
            4'd2:    r_code = 7'h5B;
            4'd3:    r_code = 7'h4F;
            4'd4:    r_code = 7'h66;
            4'd5:    r_code = 7'h6D;
            4'd6:    r_code = 7'h7D;
            4'd7:    r_code = 7'h07;
            4'd8:    r_code = 7'h7F;
            4'd9:    r_code = 7'h6F;
            default: r_code = SEG_BLANK;
        endcase
        return r_code;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// rtl/seg7_scan_driver_bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
    import seg7_scan_driver_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    // {bcd digits, remaining binary bits}; the BCD half fills from the left
    logic [BCD_W+BIN_W-1:0] r_shift;
    logic [4:0]             r_step;
    logic                   r_busy;
    logic                   r_done;
    logic [BCD_W+BIN_W-1:0] w_adj;

    // Add-3 correction on every BCD nibble that would overflow after the shift
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 5; i++) begin
            if (w_adj[BIN_W+4*i +: 4] >= 4'd5) begin
                w_adj[BIN_W+4*i +: 4] = w_adj[BIN_W+4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then one correct-and-shift per cycle for 16 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_shift <= w_adj << 1;
                r_step  <= r_step + 5'd1;
                if (r_step == 5'd15) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                r_shift <= {{BCD_W{1'b0}}, bin};
                r_step  <= '0;
                r_busy  <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_shift[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment driver with BCD conversion
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int          SCAN_DIV       = 12000,
    parameter int          BLANK_CYC      = 120,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] ID_BCD         = 16'h0029
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         display_mode,
    input  logic [BIN_W-1:0]   display_data,
    output logic [7:0]         seg,
    output logic [3:0]         dig_sel,
    output logic               conv_busy
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [7:0]    POL_MASK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [BIN_W-1:0] r_src;
    logic [BCD_W-1:0] r_bcd;
    logic [PW-1:0]    r_presc;
    logic [1:0]       r_idx;
    logic [7:0]       r_seg;
    logic [3:0]       r_dig;

    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [BCD_W-1:0] w_bcd;
    logic             w_wrap;
    logic [PW-1:0]    w_presc_nxt;
    logic [1:0]       w_idx_nxt;
    logic [3:0]       w_digit;
    logic [3:0]       w_id_digit;
    logic             w_lead_zero;
    logic [6:0]       w_code;
    logic [3:0]       w_dig;

    assign w_start = !w_busy && (display_data != r_src);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (display_data),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Latch the value being converted and commit the whole result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0;
            r_bcd <= '0;
        end else begin
            if (w_start) begin
                r_src <= display_data;
            end
            if (w_done) begin
                r_bcd <= w_bcd;
            end
        end
    end

    // Next slot position; outputs are registered from these so they line up with the counters
    always_comb begin
        w_wrap      = (r_presc == PRESC_MAX);
        w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
        w_idx_nxt   = w_wrap ? r_idx - 2'd1 : r_idx;
    end

    // Digit selection, leading-zero blanking, overflow dash and mode handling
    always_comb begin
        w_digit    = r_bcd[{w_idx_nxt, 2'b00} +: 4];
        w_id_digit = ID_BCD[{w_idx_nxt, 2'b00} +: 4];
        case (w_idx_nxt)
            2'd3:    w_lead_zero = (r_bcd[15:12] == 4'd0);
            2'd2:    w_lead_zero = (r_bcd[15:8]  == 8'd0);
            2'd1:    w_lead_zero = (r_bcd[15:4]  == 12'd0);
            default: w_lead_zero = 1'b0;
        endcase
        w_code = SEG_BLANK;
        if (display_mode == MODE_ID) begin
            w_code = seg7_encode(w_id_digit);
        end else if (display_mode == MODE_DATA) begin
            if (r_bcd[19:16] != 4'd0) begin
                w_code = SEG_DASH;
            end else if (!w_lead_zero) begin
                w_code = seg7_encode(w_digit);
            end
        end
        w_dig = (w_presc_nxt < BLANK_END) ? 4'b0000 : (4'b0001 << w_idx_nxt);
    end

    // Prescaler, digit index and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= POL_MASK;
            r_dig   <= POL_MASK[3:0];
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_dig   <= w_dig ^ POL_MASK[3:0];
            if (w_wrap) begin
                r_seg <= {1'b0, w_code} ^ POL_MASK;
            end
        end
    end

    assign seg       = r_seg;
    assign dig_sel   = r_dig;
    assign conv_busy = w_busy;

endmodule
